// File: rtl/fp_result_packer.sv
// Packs 32-bit FIFO results LANES-per-beat onto AXI4-Stream, TLAST every BEATS_PER_PKT beats; flush closes a beat/packet early.
// Optional build macro FP_PACK_STATS_EN adds packet/word/flush statistics counters.
module fp_result_packer #(
  parameter int FP_DATA_WIDTH       = 32,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int BEATS_PER_PKT       = 4
) (
  input  logic                             aclk,
  input  logic                             srst,
  input  logic [FP_DATA_WIDTH-1:0]         fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST
`ifdef FP_PACK_STATS_EN
  ,
  output logic [31:0]                      stat_pkt_cnt,
  output logic [31:0]                      stat_word_cnt,
  output logic [15:0]                      stat_flush_cnt
`endif
);

  localparam int LANES  = C_M_AXIS_DATA_WIDTH / FP_DATA_WIDTH;
  localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int BPL    = FP_DATA_WIDTH / 8;
  localparam int LCW    = $clog2(LANES + 1);

  typedef enum logic {S_FILL, S_SEND} state_t;

  state_t                           r_state;
  logic [LCW-1:0]                   r_lane_cnt;
  logic [7:0]                       r_beat_cnt;
  logic                             r_rd_en_d;
  logic                             r_flush_pend;
  logic                             r_flush_beat;
  logic                             r_tvalid;
  logic                             r_tlast;
  logic [KEEP_W-1:0]                r_tkeep;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   r_data;

  logic [LCW:0]                     w_fill_sum;
  logic                             w_rd_en;
  logic                             w_hs;
  logic                             w_lane_last;
  logic                             w_full_last;
  logic [KEEP_W-1:0]                w_part_keep;

  // Counting the in-flight read keeps captures from ever overrunning the lane array.
  assign w_fill_sum  = {1'b0, r_lane_cnt} + {{LCW{1'b0}}, r_rd_en_d};
  assign w_rd_en     = !srst && (r_state == S_FILL) && !fifo_empty && !r_flush_pend &&
                       (w_fill_sum < (LCW+1)'(LANES));
  assign w_hs        = r_tvalid && M_AXIS_TREADY;
  assign w_lane_last = (r_lane_cnt == LCW'(LANES - 1));
  assign w_full_last = (r_beat_cnt == 8'(BEATS_PER_PKT - 1));

  always_comb begin
    w_part_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LCW'(i) < r_lane_cnt) w_part_keep[i*BPL +: BPL] = '1;
    end
  end

  always_ff @(posedge aclk or posedge srst) begin
    if (srst) begin
      r_state      <= S_FILL;
      r_lane_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_rd_en_d    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_flush_beat <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tkeep      <= '0;
      r_data       <= '0;
    end else begin
      r_rd_en_d <= w_rd_en;
      if (flush) r_flush_pend <= 1'b1;
      case (r_state)
        S_FILL: begin
          if (r_rd_en_d) begin
            for (int i = 0; i < LANES; i++) begin
              if (r_lane_cnt == LCW'(i)) r_data[i*FP_DATA_WIDTH +: FP_DATA_WIDTH] <= fifo_dout;
            end
            r_lane_cnt <= r_lane_cnt + 1'b1;
            if (w_lane_last) begin
              r_state      <= S_SEND;
              r_tvalid     <= 1'b1;
              r_tkeep      <= '1;
              r_tlast      <= w_full_last;
              r_flush_beat <= 1'b0;
            end
          end else if (r_flush_pend) begin
            // With no lanes captured the partial keep is all-zero, giving the null closing beat.
            if (r_lane_cnt != '0 || r_beat_cnt != '0) begin
              r_state      <= S_SEND;
              r_tvalid     <= 1'b1;
              r_tkeep      <= w_part_keep;
              r_tlast      <= 1'b1;
              r_flush_beat <= 1'b1;
            end else begin
              r_flush_pend <= flush;
            end
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_state    <= S_FILL;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tkeep    <= '0;
            r_data     <= '0;
            r_lane_cnt <= '0;
            r_beat_cnt <= r_tlast ? 8'd0 : r_beat_cnt + 8'd1;
            if (r_flush_beat) r_flush_pend <= flush;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign M_AXIS_TDATA  = r_data;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;

`ifdef FP_PACK_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_word_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge aclk or posedge srst) begin
    if (srst) begin
      r_pkt_cnt   <= '0;
      r_word_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hs && r_tlast)      r_pkt_cnt   <= r_pkt_cnt + 32'd1;
      if (r_rd_en_d)            r_word_cnt  <= r_word_cnt + 32'd1;
      if (w_hs && r_flush_beat) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stat_pkt_cnt   = r_pkt_cnt;
  assign stat_word_cnt  = r_word_cnt;
  assign stat_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: table of scenarios plus random traffic, checked against a queue-based packing model.
module tb_fp_result_packer;
  localparam int FPW   = 32;
  localparam int DW    = 256;
  localparam int BPP   = 4;
  localparam int LANES = DW / FPW;
  localparam int KW    = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    int          nwords;
    int          fmode;
    int          rmode;
    bit          rnd;
    int          exp_beats;
    int          exp_rd;
    logic [31:0] exp_keep;
    bit          exp_last;
  } vec_t;

  logic           aclk;
  logic           srst;
  logic [FPW-1:0] fifo_dout;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic           flush;
  logic [DW-1:0]  M_AXIS_TDATA;
  logic [KW-1:0]  M_AXIS_TKEEP;
  logic           M_AXIS_TVALID;
  logic           M_AXIS_TREADY;
  logic           M_AXIS_TLAST;
`ifdef FP_PACK_STATS_EN
  logic [31:0]    stat_pkt_cnt;
  logic [31:0]    stat_word_cnt;
  logic [15:0]    stat_flush_cnt;
`endif

  fp_result_packer #(
    .FP_DATA_WIDTH(FPW), .C_M_AXIS_DATA_WIDTH(DW), .BEATS_PER_PKT(BPP)
  ) dut (
    .aclk(aclk), .srst(srst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST)
`ifdef FP_PACK_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_word_cnt(stat_word_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int rmode = 0;

  // Result FIFO model: standard mode, dout valid the cycle after rd_en.
  logic [31:0] mem [0:4095];
  int wp = 0;
  int rp = 0;
  int underflow = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge aclk) begin
    if (fifo_rd_en) begin
      if (rp == wp) underflow <= underflow + 1;
      fifo_dout <= mem[rp % 4096];
      rp <= rp + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wp % 4096] = w;
    wp++;
  endtask

  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = ($time / 10) % 3 == 0;
        default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: accepted beats, read strobes, reads during SEND, hold stability.
  beat_t obq[$];
  int rd_total = 0;
  int rd_in_send = 0;
  int unstable = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  beat_t pb;

  always @(negedge aclk) begin
    if (!srst) begin
      if (M_AXIS_TVALID && M_AXIS_TREADY) obq.push_back({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST});
      if (fifo_rd_en) rd_total <= rd_total + 1;
      if (fifo_rd_en && M_AXIS_TVALID) rd_in_send <= rd_in_send + 1;
      if (pv && !pr && !(M_AXIS_TVALID && {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} == pb))
        unstable <= unstable + 1;
      pv <= M_AXIS_TVALID;
      pr <= M_AXIS_TREADY;
      pb <= {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
    end else begin
      pv <= 1'b0;
    end
  end

  // Reference model: words accumulate into lanes; a beat leaves every LANES words or on flush.
  beat_t exq[$];
  logic [31:0] mlanes[$];
  int mbeat = 0;

  function automatic void m_emit(input bit last);
    beat_t b;
    b.d = '0;
    b.k = '0;
    b.l = last;
    foreach (mlanes[i]) begin
      b.d[i*FPW +: FPW] = mlanes[i];
      b.k[i*(FPW/8) +: FPW/8] = '1;
    end
    exq.push_back(b);
    mlanes.delete();
  endfunction

  function automatic void m_push(input logic [31:0] w);
    bit last;
    mlanes.push_back(w);
    if (mlanes.size() == LANES) begin
      last = (mbeat == BPP - 1);
      m_emit(last);
      mbeat = last ? 0 : mbeat + 1;
    end
  endfunction

  function automatic void m_flush();
    if (mlanes.size() > 0 || mbeat > 0) begin
      m_emit(1'b1);
      mbeat = 0;
    end
  endfunction

  function automatic logic [31:0] f32_of(input int k);
    int e = 0;
    for (int i = 0; i < 31; i++) if (((k >> i) & 1) == 1) e = i;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h7FFFFF)};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_beats(input string name, input int o0, input int e0);
    for (int i = 0; i < exq.size() - e0; i++) begin
      total++;
      if (o0 + i >= obq.size()) begin
        bad++;
        $display("FAIL %s beat %0d: got nothing expected keep=%h last=%b", name, i, exq[e0+i].k, exq[e0+i].l);
      end else if (obq[o0+i] !== exq[e0+i]) begin
        bad++;
        $display("FAIL %s beat %0d: got d=%h k=%h l=%b expected d=%h k=%h l=%b", name, i,
                 obq[o0+i].d, obq[o0+i].k, obq[o0+i].l, exq[e0+i].d, exq[e0+i].k, exq[e0+i].l);
      end
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 3000) begin
      @(negedge aclk);
      n++;
      q = fifo_empty ? q + 1 : 0;
    end
    if (q < 3) begin
      total++; bad++;
      $display("FAIL fifo_drain: got not empty expected empty within 3000 cycles");
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (obq.size() < target && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    if (obq.size() < target) begin
      total++; bad++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", obq.size(), target);
    end
    repeat (12) @(negedge aclk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int o0 = obq.size();
    int e0 = exq.size();
    int r0 = rd_total;
    int n = 0;
    int t = 0;
    logic [31:0] w;
    rmode = v.rmode;
    @(posedge aclk);
    #1;
    for (int k = 0; k < v.nwords; k++) begin
      w = v.rnd ? $urandom() : f32_of(k + 1);
      push(w);
      m_push(w);
    end
    if (v.fmode == 1) begin
      wait_quiet();
      pulse_flush();
      m_flush();
    end else if (v.fmode == 2) begin
      while (n < 8 && t < 100) begin
        @(negedge aclk);
        t++;
        if (fifo_rd_en) n++;
      end
      pulse_flush();
      m_flush();
    end
    wait_beats(o0 + exq.size() - e0);
    chk($sformatf("vec%0d_beats", id), 256'(obq.size() - o0), 256'(v.exp_beats));
    chk($sformatf("vec%0d_rd_en", id), 256'(rd_total - r0), 256'(v.exp_rd));
    chk_beats($sformatf("vec%0d", id), o0, e0);
    if (v.exp_beats > 0 && obq.size() > o0) begin
      chk($sformatf("vec%0d_last_keep", id), 256'(obq[obq.size()-1].k), 256'(v.exp_keep));
      chk($sformatf("vec%0d_last_tlast", id), 256'(obq[obq.size()-1].l), 256'(v.exp_last));
    end
  endtask

  vec_t tbl[7];

  initial begin
    int o0;
    int e0;
    logic [31:0] w;
    tbl[0] = '{32, 0, 0, 0, 4, 32, 32'hFFFFFFFF, 1'b1};
    tbl[1] = '{32, 0, 1, 0, 4, 32, 32'hFFFFFFFF, 1'b1};
    tbl[2] = '{11, 1, 0, 0, 2, 11, 32'h00000FFF, 1'b1};
    tbl[3] = '{16, 1, 0, 0, 3, 16, 32'h00000000, 1'b1};
    tbl[4] = '{0,  1, 0, 0, 0, 0,  32'h00000000, 1'b0};
    tbl[5] = '{8,  2, 0, 0, 2, 8,  32'h00000000, 1'b1};
    tbl[6] = '{20, 1, 2, 1, 3, 20, 32'h0000FFFF, 1'b1};

    srst  = 1'b1;
    flush = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    chk("rst_tlast", 256'(M_AXIS_TLAST), 256'(0));
    chk("rst_tdata", 256'(M_AXIS_TDATA), 256'(0));
    chk("rst_tkeep", 256'(M_AXIS_TKEEP), 256'(0));
    chk("rst_rd_en", 256'(fifo_rd_en), 256'(0));
`ifdef FP_PACK_STATS_EN
    chk("rst_stat_pkt", 256'(stat_pkt_cnt), 256'(0));
    chk("rst_stat_word", 256'(stat_word_cnt), 256'(0));
    chk("rst_stat_flush", 256'(stat_flush_cnt), 256'(0));
`endif
    @(posedge aclk);
    #1;
    srst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      o0 = obq.size();
      run_vec(tbl[i], i);
      if (i == 0 && obq.size() > o0) begin
        chk("vec0_lane0", 256'(obq[o0].d[31:0]), 256'(32'h3F800000));
        chk("vec0_lane7", 256'(obq[o0].d[255:224]), 256'(32'h41000000));
`ifdef FP_PACK_STATS_EN
        chk("stat_word_after_vec0", 256'(stat_word_cnt), 256'(32));
        chk("stat_pkt_after_vec0", 256'(stat_pkt_cnt), 256'(1));
`endif
      end
`ifdef FP_PACK_STATS_EN
      if (i == 2) chk("stat_flush_after_vec2", 256'(stat_flush_cnt), 256'(1));
`endif
    end

    // Random bursts with random backpressure and occasional flushes.
    o0 = obq.size();
    e0 = exq.size();
    rmode = 2;
    for (int r = 0; r < 8; r++) begin
      @(posedge aclk);
      #1;
      for (int k = 0; k < int'($urandom_range(1, 20)); k++) begin
        w = $urandom();
        push(w);
        m_push(w);
      end
      if ($urandom_range(0, 1) == 1) begin
        wait_quiet();
        pulse_flush();
        m_flush();
      end
    end
    wait_quiet();
    pulse_flush();
    m_flush();
    wait_beats(o0 + exq.size() - e0);
    chk("rand_beats", 256'(obq.size() - o0), 256'(exq.size() - e0));
    chk_beats("rand", o0, e0);

    // Reset with five lanes captured and TVALID low.
    rmode = 0;
    @(posedge aclk);
    #1;
    for (int k = 0; k < 5; k++) push(32'hDEAD0000 + 32'(k));
    wait_quiet();
    chk("pre_rst_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    @(posedge aclk);
    #3;
    srst = 1'b1;
    #1;
    chk("async_rst_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    chk("async_rst_tdata", 256'(M_AXIS_TDATA), 256'(0));
    chk("async_rst_tkeep", 256'(M_AXIS_TKEEP), 256'(0));
    chk("async_rst_tlast", 256'(M_AXIS_TLAST), 256'(0));
`ifdef FP_PACK_STATS_EN
    chk("async_rst_stat_word", 256'(stat_word_cnt), 256'(0));
`endif
    mlanes.delete();
    mbeat = 0;
    o0 = obq.size();
    e0 = exq.size();
    for (int k = 0; k < 8; k++) begin
      w = 32'hC0DE0000 + 32'(k);
      push(w);
      m_push(w);
    end
    @(negedge aclk);
    chk("rst_rd_en_blocked", 256'(fifo_rd_en), 256'(0));
    @(posedge aclk);
    #1;
    srst = 1'b0;
    wait_quiet();
    pulse_flush();
    m_flush();
    wait_beats(o0 + exq.size() - e0);
    chk("post_rst_beats", 256'(obq.size() - o0), 256'(2));
    chk_beats("post_rst", o0, e0);

    chk("fifo_underflow", 256'(underflow), 256'(0));
    chk("rd_en_in_send", 256'(rd_in_send), 256'(0));
    chk("hold_stability", 256'(unstable), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
